fetch_ctrl: RTL

Instruction-fetch sequencer for the rv64i_zba pipeline. It owns the fetch PC and drives the address of the combinational instruction memory. Each fetched {pc, instr} pair goes into a small FIFO, which presents instructions to the decode stage over a valid/ready handshake. It also handles redirects (branch/jump/flush) from later stages and halts on a misaligned redirect target.

---
 rtl/fetch_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: fetch PC, redirect/fault handling, fetch buffer toward decode
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_en,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic [63:0]                  imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic                         if_valid,
    output logic [63:0]                  if_pc,
    output logic [31:0]                  if_instr,
    input  logic                         id_ready,
    output logic                         fetch_fault,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [63:0]     pc_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic            fault_q;
    logic [63:0]     pc_mem    [BUF_DEPTH];
    logic [31:0]     instr_mem [BUF_DEPTH];
    logic            push;
    logic            pop;
    logic            redirect_misaligned;

    assign imem_addr   = pc_q;
    assign if_valid    = (count_q != '0);
    assign if_pc       = pc_mem[rd_ptr_q];
    assign if_instr    = instr_mem[rd_ptr_q];
    assign fetch_fault = fault_q;
    assign buf_count   = count_q;

    // HALT with fetch_en high may push directly so resuming costs no bubble.
    always_comb begin
        state_d             = state_q;
        redirect_misaligned = (redirect_pc[1:0] != 2'b00);
        pop                 = if_valid && id_ready && !redirect_valid;
        push                = (state_q != ST_FAULT) && fetch_en && !redirect_valid
                              && ((count_q < DEPTH_C) || pop);
        if (redirect_valid) begin
            if (redirect_misaligned) begin
                state_d = ST_FAULT;
            end else begin
                state_d = fetch_en ? ST_RUN : ST_HALT;
            end
        end else begin
            case (state_q)
                ST_RUN:   state_d = fetch_en ? ST_RUN : ST_HALT;
                ST_HALT:  state_d = fetch_en ? ST_RUN : ST_HALT;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_FAULT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                pc_q     <= {redirect_pc[63:2], 2'b00};
                fault_q  <= redirect_misaligned;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    pc_q     <= pc_q + 64'd4;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Entry storage needs no reset: validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
